// File: rtl/rvjtag_tap_dmi.sv
// JTAG TAP plus RISC-V debug transport: IDCODE/DTMCS/DMI/BYPASS registers and a
// valid/ready DMI request channel with outstanding-op tracking and sticky status.
//
// state    | meaning
// TLR      | test-logic-reset, IR forced to IDCODE
// RTI      | run-test/idle
// SEL_*    | select DR/IR column
// CAP_*    | parallel load of shift register
// SHIFT_*  | serial shift, LSB first
// EXIT*_*  | exit from shift/pause
// PAUSE_*  | shift paused
// UPD_*    | commit shifted value
module rvjtag_tap_dmi #(
    parameter int                  AWIDTH    = 7,
    parameter int                  IR_WIDTH  = 5,
    parameter logic [IR_WIDTH-1:0] IR_IDCODE = 'h01,
    parameter logic [IR_WIDTH-1:0] IR_DTMCS  = 'h10,
    parameter logic [IR_WIDTH-1:0] IR_DMI    = 'h11,
    parameter int                  IDLE_HINT = 1
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_en,
    input  logic [30:0]       jtag_id,
    input  logic [3:0]        version,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [AWIDTH-1:0] dmi_req_addr,
    output logic [31:0]       dmi_req_data,
    output logic [1:0]        dmi_req_op,
    input  logic              dmi_rsp_valid,
    input  logic [31:0]       dmi_rsp_data,
    input  logic [1:0]        dmi_rsp_resp,
    output logic              dmi_hard_reset
);
    localparam int DMI_W = AWIDTH + 34;
    localparam int SR_W  = (DMI_W > IR_WIDTH) ? DMI_W : IR_WIDTH;
    localparam int LW    = $clog2(SR_W);
    localparam logic [2:0] IDLE3 = 3'(IDLE_HINT);
    localparam logic [5:0] ABITS = 6'(AWIDTH);

    localparam logic [3:0] TLR      = 4'd0;
    localparam logic [3:0] RTI      = 4'd1;
    localparam logic [3:0] SEL_DR   = 4'd2;
    localparam logic [3:0] CAP_DR   = 4'd3;
    localparam logic [3:0] SHIFT_DR = 4'd4;
    localparam logic [3:0] EXIT1_DR = 4'd5;
    localparam logic [3:0] PAUSE_DR = 4'd6;
    localparam logic [3:0] EXIT2_DR = 4'd7;
    localparam logic [3:0] UPD_DR   = 4'd8;
    localparam logic [3:0] SEL_IR   = 4'd9;
    localparam logic [3:0] CAP_IR   = 4'd10;
    localparam logic [3:0] SHIFT_IR = 4'd11;
    localparam logic [3:0] EXIT1_IR = 4'd12;
    localparam logic [3:0] PAUSE_IR = 4'd13;
    localparam logic [3:0] EXIT2_IR = 4'd14;
    localparam logic [3:0] UPD_IR   = 4'd15;

    localparam logic [1:0] SEL_BYP = 2'd0;
    localparam logic [1:0] SEL_ID  = 2'd1;
    localparam logic [1:0] SEL_DTM = 2'd2;
    localparam logic [1:0] SEL_DMI = 2'd3;

    logic [3:0]          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic                tdo_q, tdo_d;
    logic [1:0]          dr_sel;
    logic [LW-1:0]       dr_len_m1;
    logic [31:0]         dtmcs_cap;
    logic [1:0]          cap_op;

    logic                req_valid_q, req_valid_d;
    logic [AWIDTH-1:0]   req_addr_q, req_addr_d;
    logic [31:0]         req_data_q, req_data_d;
    logic [1:0]          req_op_q, req_op_d;
    logic                outstanding_q, outstanding_d;
    logic [1:0]          sticky_q, sticky_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic [AWIDTH-1:0]   last_addr_q, last_addr_d;
    logic                hard_reset_q, hard_reset_d;
    logic                out_eff;
    logic [1:0]          sticky_eff;
    logic [1:0]          up_op;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:      state_d = tms ? TLR      : RTI;
            RTI:      state_d = tms ? SEL_DR   : RTI;
            SEL_DR:   state_d = tms ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = tms ? SEL_DR   : RTI;
            SEL_IR:   state_d = tms ? TLR      : CAP_IR;
            CAP_IR:   state_d = tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = tms ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    always_comb begin
        dr_sel    = SEL_BYP;
        dr_len_m1 = '0;
        if (ir_q == IR_IDCODE) begin
            dr_sel    = SEL_ID;
            dr_len_m1 = LW'(31);
        end else if (ir_q == IR_DTMCS) begin
            dr_sel    = SEL_DTM;
            dr_len_m1 = LW'(31);
        end else if (ir_q == IR_DMI) begin
            dr_sel    = SEL_DMI;
            dr_len_m1 = LW'(DMI_W - 1);
        end
    end

    assign dtmcs_cap = {14'b0, 2'b00, 1'b0, IDLE3, sticky_q, ABITS, version};
    assign cap_op    = (sticky_q != 2'd0) ? sticky_q : (outstanding_q ? 2'd3 : 2'd0);

    always_comb begin
        sr_d = sr_q;
        case (state_q)
            CAP_IR: begin
                sr_d      = '0;
                sr_d[1:0] = 2'b01;
            end
            SHIFT_IR: begin
                sr_d             = sr_q >> 1;
                sr_d[IR_WIDTH-1] = tdi;
            end
            CAP_DR: begin
                sr_d = '0;
                case (dr_sel)
                    SEL_ID:  sr_d[31:0]      = {jtag_id, 1'b1};
                    SEL_DTM: sr_d[31:0]      = dtmcs_cap;
                    SEL_DMI: sr_d[DMI_W-1:0] = {last_addr_q, rsp_data_q, cap_op};
                    default: sr_d            = '0;
                endcase
            end
            SHIFT_DR: begin
                sr_d            = sr_q >> 1;
                sr_d[dr_len_m1] = tdi;
            end
            default: sr_d = sr_q;
        endcase
    end

    // IR and TDO change on the falling edge so the probe sees stable values at rising tck.
    always_comb begin
        ir_d = ir_q;
        if (state_q == TLR)
            ir_d = IR_IDCODE;
        else if (state_q == UPD_IR)
            ir_d = sr_q[IR_WIDTH-1:0];
        tdo_d = sr_q[0];
    end

    assign up_op = sr_q[1:0];

    // A response landing in the same cycle as an Update-DR is applied first, so the new op sees its effect.
    always_comb begin
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_op_d     = req_op_q;
        rsp_data_d   = rsp_data_q;
        last_addr_d  = last_addr_q;
        hard_reset_d = 1'b0;
        out_eff      = outstanding_q;
        sticky_eff   = sticky_q;

        if (req_valid_q && dmi_req_ready)
            req_valid_d = 1'b0;

        if (dmi_rsp_valid && outstanding_q) begin
            rsp_data_d = dmi_rsp_data;
            out_eff    = 1'b0;
            if (dmi_rsp_resp != 2'd0 && sticky_q == 2'd0)
                sticky_eff = 2'd2;
        end

        outstanding_d = out_eff;
        sticky_d      = sticky_eff;

        if (state_q == UPD_DR && dr_sel == SEL_DTM) begin
            if (sr_q[16])
                sticky_d = 2'd0;
            if (sr_q[17]) begin
                sticky_d      = 2'd0;
                outstanding_d = 1'b0;
                req_valid_d   = 1'b0;
                hard_reset_d  = 1'b1;
            end
        end else if (state_q == UPD_DR && dr_sel == SEL_DMI && sticky_eff == 2'd0) begin
            if (out_eff) begin
                sticky_d = 2'd3;
            end else if (up_op == 2'd1 || up_op == 2'd2) begin
                req_valid_d   = 1'b1;
                req_addr_d    = sr_q[DMI_W-1:34];
                req_data_d    = sr_q[33:2];
                req_op_d      = up_op;
                last_addr_d   = sr_q[DMI_W-1:34];
                outstanding_d = 1'b1;
            end
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q       <= TLR;
            sr_q          <= '0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_op_q      <= '0;
            outstanding_q <= 1'b0;
            sticky_q      <= '0;
            rsp_data_q    <= '0;
            last_addr_q   <= '0;
            hard_reset_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            req_op_q      <= req_op_d;
            outstanding_q <= outstanding_d;
            sticky_q      <= sticky_d;
            rsp_data_q    <= rsp_data_d;
            last_addr_q   <= last_addr_d;
            hard_reset_q  <= hard_reset_d;
        end
    end

    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            ir_q  <= IR_IDCODE;
            tdo_q <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            tdo_q <= tdo_d;
        end
    end

    assign tdo            = tdo_q;
    assign tdo_en         = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
    assign dmi_req_valid  = req_valid_q;
    assign dmi_req_addr   = req_addr_q;
    assign dmi_req_data   = req_data_q;
    assign dmi_req_op     = req_op_q;
    assign dmi_hard_reset = hard_reset_q;
endmodule

// File: tb/tb_rvjtag_tap_dmi.sv
// Directed bench for rvjtag_tap_dmi: drives the TAP bit by bit and checks captured
// DR contents and the DMI request/response side against hand-computed values.
module tb_rvjtag_tap_dmi;
    localparam logic [30:0] JTAG_ID = 31'h1A2B_3C4D;
    localparam logic [31:0] IDCODE  = {JTAG_ID, 1'b1};

    logic        tck = 1'b0;
    logic        trst = 1'b0;
    logic        tms = 1'b1;
    logic        tdi = 1'b0;
    logic        tdo;
    logic        tdo_en;
    logic [3:0]  version = 4'd1;
    logic        dmi_req_valid;
    logic        dmi_req_ready = 1'b0;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_valid = 1'b0;
    logic [31:0] dmi_rsp_data = '0;
    logic [1:0]  dmi_rsp_resp = '0;
    logic        dmi_hard_reset;

    int   n_pass = 0;
    int   n_total = 0;
    logic en_ok = 1'b1;

    always #5 tck = ~tck;

    rvjtag_tap_dmi dut (
        .tck(tck), .trst(trst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .jtag_id(JTAG_ID), .version(version),
        .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
        .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
        .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_resp(dmi_rsp_resp),
        .dmi_hard_reset(dmi_hard_reset)
    );

    function automatic logic [63:0] dmi_vec(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    task automatic scan_ir(input logic [4:0] din, output logic [4:0] dout);
        dout = '0;
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 5; i++) begin
            dout[i] = tdo;
            tick(i == 4, din[i]);
        end
        tick(1, 0); tick(0, 0);
    endtask

    task automatic scan_dr(input int len, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        tick(1, 0); tick(0, 0); tick(0, 0);
        en_ok = en_ok & (tdo_en === 1'b1);
        for (int i = 0; i < len; i++) begin
            dout[i] = tdo;
            tick(i == len - 1, din[i]);
        end
        tick(1, 0); tick(0, 0);
        en_ok = en_ok & (tdo_en === 1'b0);
    endtask

    task automatic set_ir(input logic [4:0] v);
        logic [4:0] unused_cap;
        scan_ir(v, unused_cap);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge tck);
        #1;
        n_total++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_hard_reset, tdo, tdo_en} !== '0)
            $display("FAIL reset_outputs: got valid=%b addr=%h data=%h op=%h hr=%b tdo=%b en=%b expected all zero",
                     dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op, dmi_hard_reset, tdo, tdo_en);
        else n_pass++;
        trst = 1'b1;
        tick(0, 0);
    endtask

    task automatic test_idcode;
        logic [63:0] dout;
        logic [4:0]  irc;
        scan_dr(32, 64'h0, dout);
        n_total++;
        if (dout[31:0] !== IDCODE) $display("FAIL idcode_default: got %h expected %h", dout[31:0], IDCODE);
        else n_pass++;
        scan_ir(5'h01, irc);
        n_total++;
        if (irc !== 5'b00001) $display("FAIL ir_capture: got %b expected 00001", irc);
        else n_pass++;
        scan_dr(32, 64'h0, dout);
        n_total++;
        if (dout[31:0] !== IDCODE) $display("FAIL idcode_scan: got %h expected %h", dout[31:0], IDCODE);
        else n_pass++;
        n_total++;
        if (en_ok !== 1'b1) $display("FAIL tdo_en: got %b expected 1", en_ok);
        else n_pass++;
        set_ir(5'h10);
        repeat (5) tick(1, 0);
        tick(0, 0);
        scan_dr(32, 64'h0, dout);
        n_total++;
        if (dout[31:0] !== IDCODE) $display("FAIL tlr_ir_idcode: got %h expected %h", dout[31:0], IDCODE);
        else n_pass++;
    endtask

    task automatic test_dtmcs;
        logic [63:0] dout;
        set_ir(5'h10);
        scan_dr(32, 64'h0, dout);
        n_total++;
        if (dout[31:0] !== 32'h0000_1071) $display("FAIL dtmcs_capture: got %h expected 00001071", dout[31:0]);
        else n_pass++;
    endtask

    task automatic test_dmi_rw;
        logic [63:0] dout;
        set_ir(5'h11);
        scan_dr(41, dmi_vec(7'h10, 32'hDEADBEEF, 2'd2), dout);
        n_total++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op} !== {1'b1, 7'h10, 32'hDEADBEEF, 2'd2})
            $display("FAIL write_req: got v=%b a=%h d=%h op=%h expected v=1 a=10 d=deadbeef op=2",
                     dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op);
        else n_pass++;
        repeat (3) tick(0, 0);
        n_total++;
        if ({dmi_req_valid, dmi_req_addr} !== {1'b1, 7'h10}) $display("FAIL write_hold: got v=%b a=%h expected v=1 a=10", dmi_req_valid, dmi_req_addr);
        else n_pass++;
        dmi_req_ready = 1'b1;
        tick(0, 0);
        dmi_req_ready = 1'b0;
        n_total++;
        if (dmi_req_valid !== 1'b0) $display("FAIL write_drop: got %b expected 0", dmi_req_valid);
        else n_pass++;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h0; dmi_rsp_resp = 2'd0;
        tick(0, 0);
        dmi_rsp_valid = 1'b0;
        scan_dr(41, dmi_vec(7'h10, 32'h0, 2'd1), dout);
        n_total++;
        if (dout !== dmi_vec(7'h10, 32'h0, 2'd0)) $display("FAIL write_done_capture: got %h expected %h", dout, dmi_vec(7'h10, 32'h0, 2'd0));
        else n_pass++;
        n_total++;
        if ({dmi_req_valid, dmi_req_op} !== {1'b1, 2'd1}) $display("FAIL read_req: got v=%b op=%h expected v=1 op=1", dmi_req_valid, dmi_req_op);
        else n_pass++;
        dmi_req_ready = 1'b1;
        tick(0, 0);
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h1234_5678;
        tick(0, 0);
        dmi_rsp_valid = 1'b0;
        scan_dr(41, 64'h0, dout);
        n_total++;
        if (dout !== dmi_vec(7'h10, 32'h1234_5678, 2'd0)) $display("FAIL read_capture: got %h expected %h", dout, dmi_vec(7'h10, 32'h1234_5678, 2'd0));
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] dout;
        scan_dr(41, dmi_vec(7'h20, 32'h1111_1111, 2'd2), dout);
        scan_dr(41, dmi_vec(7'h21, 32'h2222_2222, 2'd2), dout);
        n_total++;
        if (dout !== dmi_vec(7'h20, 32'h1234_5678, 2'd3)) $display("FAIL busy_capture: got %h expected %h", dout, dmi_vec(7'h20, 32'h1234_5678, 2'd3));
        else n_pass++;
        scan_dr(41, 64'h0, dout);
        n_total++;
        if (dout !== dmi_vec(7'h20, 32'h1234_5678, 2'd3)) $display("FAIL busy_sticky: got %h expected %h", dout, dmi_vec(7'h20, 32'h1234_5678, 2'd3));
        else n_pass++;
        n_total++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op} !== {1'b1, 7'h20, 32'h1111_1111, 2'd2})
            $display("FAIL busy_req_stable: got v=%b a=%h d=%h op=%h expected v=1 a=20 d=11111111 op=2",
                     dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_op);
        else n_pass++;
        set_ir(5'h10);
        scan_dr(32, 64'h0001_0000, dout);
        n_total++;
        if (dout[31:0] !== 32'h0000_1C71) $display("FAIL busy_dtmcs: got %h expected 00001c71", dout[31:0]);
        else n_pass++;
        n_total++;
        if ({dmi_req_valid, dmi_req_addr} !== {1'b1, 7'h20}) $display("FAIL busy_still_pending: got v=%b a=%h expected v=1 a=20", dmi_req_valid, dmi_req_addr);
        else n_pass++;
        dmi_req_ready = 1'b1;
        tick(0, 0);
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'h55AA_55AA; dmi_rsp_resp = 2'd0;
        tick(0, 0);
        dmi_rsp_valid = 1'b0;
        set_ir(5'h11);
        scan_dr(41, 64'h0, dout);
        n_total++;
        if (dout !== dmi_vec(7'h20, 32'h55AA_55AA, 2'd0)) $display("FAIL dmireset_capture: got %h expected %h", dout, dmi_vec(7'h20, 32'h55AA_55AA, 2'd0));
        else n_pass++;
    endtask

    task automatic test_failed;
        logic [63:0] dout;
        scan_dr(41, dmi_vec(7'h05, 32'h0, 2'd1), dout);
        dmi_req_ready = 1'b1;
        tick(0, 0);
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'hCAFE_F00D; dmi_rsp_resp = 2'd2;
        tick(0, 0);
        dmi_rsp_valid = 1'b0;
        scan_dr(41, dmi_vec(7'h06, 32'h1, 2'd2), dout);
        n_total++;
        if (dout !== dmi_vec(7'h05, 32'hCAFE_F00D, 2'd2)) $display("FAIL failed_capture: got %h expected %h", dout, dmi_vec(7'h05, 32'hCAFE_F00D, 2'd2));
        else n_pass++;
        n_total++;
        if (dmi_req_valid !== 1'b0) $display("FAIL failed_ignores_op: got %b expected 0", dmi_req_valid);
        else n_pass++;
        set_ir(5'h10);
        scan_dr(32, 64'h0001_0000, dout);
        n_total++;
        if (dout[31:0] !== 32'h0000_1871) $display("FAIL failed_dtmcs: got %h expected 00001871", dout[31:0]);
        else n_pass++;
        set_ir(5'h11);
        scan_dr(41, dmi_vec(7'h07, 32'h0, 2'd1), dout);
        n_total++;
        if (dmi_req_valid !== 1'b1) $display("FAIL post_reset_issue: got %b expected 1", dmi_req_valid);
        else n_pass++;
        set_ir(5'h10);
        scan_dr(32, 64'h0002_0000, dout);
        n_total++;
        if ({dmi_hard_reset, dmi_req_valid} !== 2'b10) $display("FAIL hardreset_pulse: got hr=%b v=%b expected hr=1 v=0", dmi_hard_reset, dmi_req_valid);
        else n_pass++;
        tick(0, 0);
        n_total++;
        if (dmi_hard_reset !== 1'b0) $display("FAIL hardreset_width: got %b expected 0", dmi_hard_reset);
        else n_pass++;
        dmi_rsp_valid = 1'b1; dmi_rsp_data = 32'hBAD0_BAD0; dmi_rsp_resp = 2'd2;
        tick(0, 0);
        dmi_rsp_valid = 1'b0; dmi_rsp_resp = 2'd0;
        set_ir(5'h11);
        scan_dr(41, 64'h0, dout);
        n_total++;
        if (dout !== dmi_vec(7'h07, 32'hCAFE_F00D, 2'd0)) $display("FAIL late_rsp_ignored: got %h expected %h", dout, dmi_vec(7'h07, 32'hCAFE_F00D, 2'd0));
        else n_pass++;
    endtask

    task automatic test_bypass;
        logic [63:0] dout;
        set_ir(5'h1F);
        scan_dr(8, 64'hB2, dout);
        n_total++;
        if (dout[7:0] !== 8'h64) $display("FAIL bypass_ones: got %h expected 64", dout[7:0]);
        else n_pass++;
        set_ir(5'h00);
        scan_dr(4, 64'hF, dout);
        n_total++;
        if (dout[3:0] !== 4'hE) $display("FAIL bypass_zeros: got %h expected e", dout[3:0]);
        else n_pass++;
    endtask

    task automatic test_trst_midop;
        logic [63:0] dout;
        set_ir(5'h11);
        scan_dr(41, dmi_vec(7'h33, 32'hA5A5_A5A5, 2'd2), dout);
        n_total++;
        if (dmi_req_valid !== 1'b1) $display("FAIL trst_pre_valid: got %b expected 1", dmi_req_valid);
        else n_pass++;
        #1 trst = 1'b0;
        #1;
        n_total++;
        if ({dmi_req_valid, dmi_req_addr, dmi_req_op} !== '0) $display("FAIL trst_async: got v=%b a=%h op=%h expected all zero", dmi_req_valid, dmi_req_addr, dmi_req_op);
        else n_pass++;
        @(negedge tck);
        #1 trst = 1'b1;
        tick(0, 0);
        scan_dr(32, 64'h0, dout);
        n_total++;
        if (dout[31:0] !== IDCODE) $display("FAIL trst_ir_idcode: got %h expected %h", dout[31:0], IDCODE);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_dtmcs();
        test_dmi_rw();
        test_back_to_back();
        test_failed();
        test_bypass();
        test_trst_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
